// File: rtl/umai_pkg.sv
// Shared UMAI widths and the responder state encoding used by umai_mem_slv and its RAM.
package umai_pkg;

    localparam int UMAI_ADDR_W   = 32;
    localparam int UMAI_LEN_W    = 6;
    localparam int UMAI_DATA_W   = 512;
    localparam int UMAI_BEAT_LSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } umai_slv_state_e;

    // Direction of the most recently granted command; drives the round-robin tie break.
    typedef enum logic {
        RR_WRITE = 1'b0,
        RR_READ  = 1'b1
    } umai_rr_e;

endpackage

// File: rtl/umai_mem_slv_ram.sv
// DEPTH x 512-bit 1W1R register array: synchronous write, combinational read.
// Kept as a separate module so an SRAM macro wrapper can drop in later.
module umai_mem_slv_ram
    import umai_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UMAI_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UMAI_DATA_W-1:0] rdata
);

    logic [UMAI_DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents survive rst_n so partial bursts stay visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/umai_mem_slv.sv
// UMAI responder backed by a beat-addressed memory; one burst in flight at a time.
// Optional statistics counters are built when UMAI_MEM_SLV_STATS_EN is defined.
module umai_mem_slv
    import umai_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_umai_wcmd_valid,
    output logic                   o_umai_wcmd_ready,
    input  logic [UMAI_ADDR_W-1:0] i_umai_wcmd_addr,
    input  logic [UMAI_LEN_W-1:0]  i_umai_wcmd_len,
    input  logic                   i_umai_rcmd_valid,
    output logic                   o_umai_rcmd_ready,
    input  logic [UMAI_ADDR_W-1:0] i_umai_rcmd_addr,
    input  logic [UMAI_LEN_W-1:0]  i_umai_rcmd_len,
    input  logic                   i_umai_wvalid,
    output logic                   o_umai_wready,
    input  logic [UMAI_DATA_W-1:0] i_umai_wdata,
    output logic                   o_umai_rvalid,
    input  logic                   i_umai_rready,
    output logic [UMAI_DATA_W-1:0] o_umai_rdata
`ifdef UMAI_MEM_SLV_STATS_EN
    ,
    output logic [31:0]            o_wr_beats,
    output logic [31:0]            o_rd_beats,
    output logic [15:0]            o_bursts
`endif
);

    localparam int AW = $clog2(DEPTH);

    umai_slv_state_e        state;
    umai_slv_state_e        state_nxt;
    umai_rr_e               rr_last;
    logic [AW-1:0]          ptr;
    logic [UMAI_LEN_W-1:0]  cnt;
    logic                   grant_w;
    logic                   grant_r;
    logic                   wcmd_hs;
    logic                   rcmd_hs;
    logic                   wbeat_hs;
    logic                   rbeat_hs;
    logic [AW-1:0]          wcmd_idx;
    logic [AW-1:0]          rcmd_idx;
    logic [AW-1:0]          rd_idx;
    logic [UMAI_DATA_W-1:0] ram_rdata;
    logic                   unused_addr_bits;

    assign wcmd_idx = i_umai_wcmd_addr[UMAI_BEAT_LSB +: AW];
    assign rcmd_idx = i_umai_rcmd_addr[UMAI_BEAT_LSB +: AW];

    // Sub-beat offset and bits above the array size are ignored; addresses alias modulo DEPTH.
    assign unused_addr_bits = ^{i_umai_wcmd_addr, i_umai_rcmd_addr};

    assign grant_w = i_umai_wcmd_valid && (!i_umai_rcmd_valid || (rr_last == RR_READ));
    assign grant_r = i_umai_rcmd_valid && !grant_w;

    assign wcmd_hs  = i_umai_wcmd_valid && o_umai_wcmd_ready;
    assign rcmd_hs  = i_umai_rcmd_valid && o_umai_rcmd_ready;
    assign wbeat_hs = i_umai_wvalid && o_umai_wready;
    assign rbeat_hs = o_umai_rvalid && i_umai_rready;

    // The first read beat is fetched at the command handshake, so the array is
    // addressed from the incoming command while idle and from ptr during a burst.
    assign rd_idx = (state == ST_IDLE) ? rcmd_idx : ptr;

    umai_mem_slv_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (wbeat_hs),
        .waddr (ptr),
        .wdata (i_umai_wdata),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt         = state;
        o_umai_wcmd_ready = 1'b0;
        o_umai_rcmd_ready = 1'b0;
        o_umai_wready     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_umai_wcmd_ready = grant_w;
                o_umai_rcmd_ready = grant_r;
                if (grant_w) begin
                    state_nxt = ST_WR;
                end else if (grant_r) begin
                    state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                o_umai_wready = 1'b1;
                if (i_umai_wvalid && (cnt == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD: begin
                if (rbeat_hs && (cnt == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst datapath. In RD, cnt counts beats still to be fetched after the one held in rdata.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr           <= '0;
            cnt           <= '0;
            rr_last       <= RR_READ;
            o_umai_rvalid <= 1'b0;
            o_umai_rdata  <= '0;
        end else if (wcmd_hs) begin
            ptr     <= wcmd_idx;
            cnt     <= i_umai_wcmd_len;
            rr_last <= RR_WRITE;
        end else if (rcmd_hs) begin
            ptr           <= rcmd_idx + AW'(1);
            cnt           <= i_umai_rcmd_len;
            rr_last       <= RR_READ;
            o_umai_rvalid <= 1'b1;
            o_umai_rdata  <= ram_rdata;
        end else if (wbeat_hs) begin
            ptr <= ptr + AW'(1);
            if (cnt != '0) begin
                cnt <= cnt - UMAI_LEN_W'(1);
            end
        end else if (rbeat_hs) begin
            if (cnt == '0) begin
                o_umai_rvalid <= 1'b0;
            end else begin
                o_umai_rdata <= ram_rdata;
                ptr          <= ptr + AW'(1);
                cnt          <= cnt - UMAI_LEN_W'(1);
            end
        end
    end

`ifdef UMAI_MEM_SLV_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_beats <= '0;
            o_rd_beats <= '0;
            o_bursts   <= '0;
        end else begin
            if (wbeat_hs && (o_wr_beats != '1)) begin
                o_wr_beats <= o_wr_beats + 32'd1;
            end
            if (rbeat_hs && (o_rd_beats != '1)) begin
                o_rd_beats <= o_rd_beats + 32'd1;
            end
            if ((wcmd_hs || rcmd_hs) && (o_bursts != '1)) begin
                o_bursts <= o_bursts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_umai_mem_slv.sv
// Self-checking bench for umai_mem_slv: directed bring-up cases plus randomized bursts
// checked against an array model of the beat memory.
module tb_umai_mem_slv;

    localparam int DEPTH = 64;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_umai_wcmd_valid;
    logic         o_umai_wcmd_ready;
    logic [31:0]  i_umai_wcmd_addr;
    logic [5:0]   i_umai_wcmd_len;
    logic         i_umai_rcmd_valid;
    logic         o_umai_rcmd_ready;
    logic [31:0]  i_umai_rcmd_addr;
    logic [5:0]   i_umai_rcmd_len;
    logic         i_umai_wvalid;
    logic         o_umai_wready;
    logic [511:0] i_umai_wdata;
    logic         o_umai_rvalid;
    logic         i_umai_rready;
    logic [511:0] o_umai_rdata;
`ifdef UMAI_MEM_SLV_STATS_EN
    logic [31:0]  o_wr_beats;
    logic [31:0]  o_rd_beats;
    logic [15:0]  o_bursts;
`endif

    umai_mem_slv #(.DEPTH(DEPTH)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_umai_wcmd_valid (i_umai_wcmd_valid),
        .o_umai_wcmd_ready (o_umai_wcmd_ready),
        .i_umai_wcmd_addr  (i_umai_wcmd_addr),
        .i_umai_wcmd_len   (i_umai_wcmd_len),
        .i_umai_rcmd_valid (i_umai_rcmd_valid),
        .o_umai_rcmd_ready (o_umai_rcmd_ready),
        .i_umai_rcmd_addr  (i_umai_rcmd_addr),
        .i_umai_rcmd_len   (i_umai_rcmd_len),
        .i_umai_wvalid     (i_umai_wvalid),
        .o_umai_wready     (o_umai_wready),
        .i_umai_wdata      (i_umai_wdata),
        .o_umai_rvalid     (o_umai_rvalid),
        .i_umai_rready     (i_umai_rready),
        .o_umai_rdata      (o_umai_rdata)
`ifdef UMAI_MEM_SLV_STATS_EN
        ,
        .o_wr_beats        (o_wr_beats),
        .o_rd_beats        (o_rd_beats),
        .o_bursts          (o_bursts)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_wr_beats = 0;
    int exp_rd_beats = 0;
    int exp_bursts = 0;
    logic [511:0] model [DEPTH];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_beat();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int beat_of(input logic [31:0] addr);
        return int'((addr >> 6) % DEPTH);
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Data phase of a write burst; entered one tick after the command handshake edge.
    task automatic wr_data(input int start_idx, input int len, input bit gaps);
        int idx = start_idx;
        int beat = 0;
        int cyc = 0;
        while (beat <= len && cyc < 2000) begin
            i_umai_wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_umai_wdata  = rand_beat();
            #1;
            check("wready_in_burst", o_umai_wready, 1'b1);
            check("rcmd_ready_busy", o_umai_rcmd_ready, 1'b0);
            check("rvalid_during_wr", o_umai_rvalid, 1'b0);
            if (i_umai_wvalid) begin
                model[idx] = i_umai_wdata;
                idx = (idx + 1) % DEPTH;
                beat++;
                exp_wr_beats++;
            end
            step();
            cyc++;
        end
        check("wr_beats_done", beat, len + 1);
        if (!gaps) check("wr_cycles", cyc, len + 1);
        i_umai_wvalid = 1'b0;
        #1;
        check("wready_after_burst", o_umai_wready, 1'b0);
    endtask

    // Data phase of a read burst. mode 0: rready always high, 1: random, 2: 1,0,0,1 pattern.
    task automatic rd_data(input int start_idx, input int len, input int mode, input bit disturb);
        int idx = start_idx;
        int beat = 0;
        int cyc = 0;
        while (beat <= len && cyc < 2000) begin
            case (mode)
                0:       i_umai_rready = 1'b1;
                1:       i_umai_rready = 1'($urandom_range(0, 1));
                default: i_umai_rready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            if (disturb) begin
                i_umai_wcmd_valid = 1'($urandom_range(0, 1));
                i_umai_wcmd_addr  = $urandom;
                i_umai_wvalid     = 1'($urandom_range(0, 1));
                i_umai_wdata      = rand_beat();
            end
            #1;
            check("rvalid_in_burst", o_umai_rvalid, 1'b1);
            check("rdata", o_umai_rdata, model[idx]);
            check("wcmd_ready_busy", o_umai_wcmd_ready, 1'b0);
            check("wready_outside_wr", o_umai_wready, 1'b0);
            if (i_umai_rready) begin
                idx = (idx + 1) % DEPTH;
                beat++;
                exp_rd_beats++;
            end
            step();
            cyc++;
        end
        check("rd_beats_done", beat, len + 1);
        i_umai_rready = 1'b0;
        if (disturb) begin
            i_umai_wcmd_valid = 1'b0;
            i_umai_wvalid     = 1'b0;
        end
        #1;
        check("rvalid_after_burst", o_umai_rvalid, 1'b0);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int len, input bit gaps);
        i_umai_wcmd_valid = 1'b1;
        i_umai_wcmd_addr  = addr;
        i_umai_wcmd_len   = 6'(len);
        #1;
        check("wcmd_ready_idle", o_umai_wcmd_ready, 1'b1);
        step();
        i_umai_wcmd_valid = 1'b0;
        exp_bursts++;
        wr_data(beat_of(addr), len, gaps);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input int len, input int mode, input bit disturb);
        i_umai_rcmd_valid = 1'b1;
        i_umai_rcmd_addr  = addr;
        i_umai_rcmd_len   = 6'(len);
        #1;
        check("rcmd_ready_idle", o_umai_rcmd_ready, 1'b1);
        check("rvalid_before_rd", o_umai_rvalid, 1'b0);
        step();
        i_umai_rcmd_valid = 1'b0;
        exp_bursts++;
        rd_data(beat_of(addr), len, mode, disturb);
    endtask

`ifdef UMAI_MEM_SLV_STATS_EN
    task automatic check_stats();
        check("stat_wr_beats", o_wr_beats, exp_wr_beats);
        check("stat_rd_beats", o_rd_beats, exp_rd_beats);
        check("stat_bursts", o_bursts, exp_bursts);
    endtask
`endif

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] b1;
        i_rst_n = 1'b0;
        i_umai_wcmd_valid = 1'b0;
        i_umai_wcmd_addr = '0;
        i_umai_wcmd_len = '0;
        i_umai_rcmd_valid = 1'b0;
        i_umai_rcmd_addr = '0;
        i_umai_rcmd_len = '0;
        i_umai_wvalid = 1'b0;
        i_umai_wdata = '0;
        i_umai_rready = 1'b0;

        // Reset values, then ten idle cycles with no change.
        step();
        check("rst_wcmd_ready", o_umai_wcmd_ready, 1'b0);
        check("rst_rcmd_ready", o_umai_rcmd_ready, 1'b0);
        check("rst_wready", o_umai_wready, 1'b0);
        check("rst_rvalid", o_umai_rvalid, 1'b0);
        check("rst_rdata", o_umai_rdata, '0);
        step();
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ready_flags", {o_umai_wcmd_ready, o_umai_rcmd_ready, o_umai_wready}, '0);
            check("idle_rvalid", o_umai_rvalid, 1'b0);
            check("idle_rdata", o_umai_rdata, '0);
        end

        // Four-beat write then read-back at full rate.
        wr_burst(32'h80, 3, 1'b0);
        rd_burst(32'h80, 3, 0, 1'b0);
`ifdef UMAI_MEM_SLV_STATS_EN
        check("stat_t2_wr", o_wr_beats, 32'd4);
        check("stat_t2_rd", o_rd_beats, 32'd4);
        check("stat_t2_bursts", o_bursts, 16'd2);
`endif

        // Fill the whole array with a maximum-length burst so every later read is defined.
        wr_burst(32'h0, 63, 1'b0);
        rd_burst(32'h0, 63, 1, 1'b0);

        // Two-beat read with the 1,0,0,1 rready pattern.
        rd_burst(32'h140, 1, 2, 1'b0);

        // Simultaneous commands: write, then read, then write again.
        i_umai_wcmd_valid = 1'b1;
        i_umai_wcmd_addr  = 32'h200;
        i_umai_wcmd_len   = 6'd2;
        i_umai_rcmd_valid = 1'b1;
        i_umai_rcmd_addr  = 32'h200;
        i_umai_rcmd_len   = 6'd2;
        #1;
        check("tie1_wcmd_ready", o_umai_wcmd_ready, 1'b1);
        check("tie1_rcmd_ready", o_umai_rcmd_ready, 1'b0);
        step();
        i_umai_wcmd_valid = 1'b0;
        exp_bursts++;
        wr_data(beat_of(32'h200), 2, 1'b0);
        i_umai_wcmd_valid = 1'b1;
        #1;
        check("tie2_rcmd_ready", o_umai_rcmd_ready, 1'b1);
        check("tie2_wcmd_ready", o_umai_wcmd_ready, 1'b0);
        step();
        i_umai_rcmd_valid = 1'b0;
        exp_bursts++;
        rd_data(beat_of(32'h200), 2, 0, 1'b0);
        i_umai_rcmd_valid = 1'b1;
        #1;
        check("tie3_wcmd_ready", o_umai_wcmd_ready, 1'b1);
        check("tie3_rcmd_ready", o_umai_rcmd_ready, 1'b0);
        step();
        i_umai_wcmd_valid = 1'b0;
        i_umai_rcmd_valid = 1'b0;
        exp_bursts++;
        wr_data(beat_of(32'h200), 2, 1'b1);

        // Burst across the top of the array wraps to beat 0.
        wr_burst(32'(63 << 6), 1, 1'b0);
        b1 = model[0];
        rd_burst(32'h0, 0, 0, 1'b0);
        check("wrap_beat0_is_b1", o_umai_rdata, b1);
        rd_burst(32'(63 << 6), 1, 1, 1'b0);
        // Address aliasing above DEPTH.
        rd_burst(32'h0001_0000 + 32'(5 << 6), 3, 0, 1'b0);

        // Asynchronous reset after two of four beats.
        i_umai_wcmd_valid = 1'b1;
        i_umai_wcmd_addr  = 32'h400;
        i_umai_wcmd_len   = 6'd3;
        #1;
        check("rstmid_wcmd_ready", o_umai_wcmd_ready, 1'b1);
        step();
        i_umai_wcmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_umai_wvalid = 1'b1;
            i_umai_wdata  = rand_beat();
            model[(beat_of(32'h400) + i) % DEPTH] = i_umai_wdata;
            step();
        end
        i_umai_wdata = rand_beat();
        i_rst_n = 1'b0;
        #1;
        check("rstmid_wready", o_umai_wready, 1'b0);
        check("rstmid_rvalid", o_umai_rvalid, 1'b0);
        i_umai_wvalid = 1'b0;
        exp_wr_beats = 0;
        exp_rd_beats = 0;
        exp_bursts = 0;
        step();
        step();
        i_rst_n = 1'b1;
        step();
        check("post_rst_flags", {o_umai_wcmd_ready, o_umai_rcmd_ready, o_umai_wready, o_umai_rvalid}, '0);
        check("post_rst_rdata", o_umai_rdata, '0);
        rd_burst(32'h400, 3, 0, 1'b0);
        wr_burst(32'h400, 3, 1'b0);
        rd_burst(32'h400, 3, 1, 1'b1);
`ifdef UMAI_MEM_SLV_STATS_EN
        check_stats();
`endif

        // Randomized bursts.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr;
            int len;
            addr = $urandom;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wr_burst(addr, len, 1'($urandom_range(0, 1)));
            end else begin
                rd_burst(addr, len, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) step();
        end
`ifdef UMAI_MEM_SLV_STATS_EN
        check_stats();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
